// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcodes, FSM state encoding and default timeout shared by the UART/ALU slice
package uart_alu_pkg;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GET_A   = 3'd1;
    localparam logic [2:0] ST_GET_B   = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    localparam int TIMEOUT_CYCLES_DEFAULT = 78125;
endpackage

// File: rtl/uart_alu_if.sv
// uart_alu_if: RX byte stream in, TX request/result and status pulses out
interface uart_alu_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_op_err;
    logic               o_overrun;
    logic               o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done,
        output o_tx_data, o_tx_start, o_busy, o_op_err, o_overrun, o_timeout
    );
    modport master (
        output i_rx_data, i_rx_done, i_tx_done,
        input  o_tx_data, o_tx_start, o_busy, o_op_err, o_overrun, o_timeout
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU; unknown opcodes give 0 and raise op_err
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
)(
    input  logic [NB_OP-1:0]   op,
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    output logic [NB_DATA-1:0] result,
    output logic               op_err
);
    always_comb begin
        result = '0;
        op_err = 1'b0;
        case (op)
            NB_OP'(OP_ADD): result = a + b;
            NB_OP'(OP_SUB): result = a - b;
            NB_OP'(OP_AND): result = a & b;
            NB_OP'(OP_OR):  result = a | b;
            NB_OP'(OP_XOR): result = a ^ b;
            NB_OP'(OP_NOR): result = ~(a | b);
            // shift amounts of NB_DATA or more saturate to zero / sign fill
            NB_OP'(OP_SRA): result = $signed(a) >>> b;
            NB_OP'(OP_SRL): result = a >> b;
            default:        op_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects opcode/A/B bytes from uart_rx, runs alu_core, sends result to uart_tx
// Optional inter-byte timeout enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
    input logic        clk,
    input logic        i_rst,
    uart_alu_if.slave  bus
);
    logic [2:0]         state, state_next;
    logic [NB_OP-1:0]   op;
    logic [NB_DATA-1:0] a, b, result, alu_result;
    logic               alu_err, timeout_hit, collecting;

    alu_core #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
        .op(op), .a(a), .b(b), .result(alu_result), .op_err(alu_err)
    );

    assign collecting = (state == ST_GET_A) || (state == ST_GET_B);

`ifdef UART_ALU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (i_rst || !collecting || bus.i_rx_done)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
    // a byte arriving in the expiry cycle takes priority over the timeout
    assign timeout_hit = collecting && !bus.i_rx_done && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:    state_next = bus.i_rx_done ? ST_GET_A : ST_IDLE;
            ST_GET_A:   state_next = bus.i_rx_done ? ST_GET_B : timeout_hit ? ST_IDLE : ST_GET_A;
            ST_GET_B:   state_next = bus.i_rx_done ? ST_EXEC : timeout_hit ? ST_IDLE : ST_GET_B;
            ST_EXEC:    state_next = ST_SEND;
            ST_SEND:    state_next = ST_WAIT_TX;
            ST_WAIT_TX: state_next = bus.i_tx_done ? ST_IDLE : ST_WAIT_TX;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            op             <= '0;
            a              <= '0;
            b              <= '0;
            result         <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_op_err   <= 1'b0;
            bus.o_overrun  <= 1'b0;
            bus.o_timeout  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && bus.i_rx_done)
                op <= bus.i_rx_data[NB_OP-1:0];
            if (state == ST_GET_A && bus.i_rx_done)
                a <= bus.i_rx_data;
            if (state == ST_GET_B && bus.i_rx_done)
                b <= bus.i_rx_data;
            if (state == ST_EXEC)
                result <= alu_result;
            bus.o_tx_start <= state == ST_EXEC;
            bus.o_busy     <= state_next != ST_IDLE;
            // op_err depends only on the latched opcode, so it can be lined up with EXEC
            bus.o_op_err   <= state == ST_GET_B && bus.i_rx_done && alu_err;
            bus.o_overrun  <= bus.i_rx_done && (state == ST_EXEC || state == ST_SEND || state == ST_WAIT_TX);
            bus.o_timeout  <= timeout_hit;
        end
    end

    assign bus.o_tx_data = result;
endmodule
